wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back stage directly downstream of the MEM stage. Consumes MEM/WB pipeline-register outputs plus late load completions returned after a data-cache miss thread switch.
- Arbitrates both sources onto the single GPR write port and buffers late loads in a small FIFO.
- Kills stale late loads overwritten by younger instructions, and requests a pipeline stall when the buffer starves.

Parameters:
- DEPTH, 4, late-load FIFO entries (power of two, >=2)
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may be blocked before wb_stall_req

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall (MEM/WB holds contents)
- flush  in  1  pipeline flush
- mem_en  in  1  MEM/WB entry valid
- mem_thread  in  2  thread of MEM/WB entry
- mem_dst_addr  in  5  destination GPR
- mem_gpr_we_  in  1  GPR write enable, active-low
- mem_out  in  32  result data
- ld_rdy  in  1  late load data valid (push request)
- ld_thread  in  2  thread of late load
- ld_dst_addr  in  5  destination GPR of late load
- ld_data  in  32  late load data
- ld_full  out  1  FIFO full; push refused
- gpr_we_  out  1  GPR write enable, active-low, registered
- gpr_thread  out  2  register-file bank select
- gpr_wr_addr  out  5  GPR write address
- gpr_wr_data  out  32  GPR write data
- wb_fwd_data  out  32  forward data, equal to gpr_wr_data
- wb_stall_req  out  1  request upstream stall so the FIFO can drain

Behaviour:
- Reset (reset=0, async):
  - gpr_we_=1; gpr_thread, gpr_wr_addr, gpr_wr_data, wb_fwd_data = 0.
  - FIFO empty, all entry valids 0, ld_full=0.
  - Starve counter 0, wb_stall_req=0.
  - Reset mid-drain discards all FIFO contents.
- Pipeline write valid: pv = mem_en & ~mem_gpr_we_ & ~stall & ~flush & (mem_dst_addr != 0).
- Output register update, every cycle, latency 1:
  - If pv: load the mem_* fields and set gpr_we_=0.
  - Else if FIFO non-empty: pop the head. gpr_we_=0 only if the head entry is valid and its ld_dst_addr != 0; otherwise gpr_we_=1 (silent drain).
  - Else: gpr_we_=1, data/address outputs hold their previous values.
- Priority: the pipeline always wins the port; the FIFO drains only in cycles with pv=0, which include stall and flush cycles.
- Push:
  - ld_full = (count == DEPTH), computed from registered count only.
  - An entry is pushed when ld_rdy & ~ld_full. The new entry's valid is 1 unless a kill applies in the same cycle (see Kill).
  - Push and pop in the same cycle: count unchanged.
  - Push when full (including a same-cycle pop): refused; the producer holds ld_rdy and ld_* stable.
  - No bypass: a load pushed into an empty FIFO reaches gpr_we_ no earlier than 2 cycles after acceptance.
- Pointers: wr/rd pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Kill: when pv=1, every resident FIFO entry with the same thread and dst_addr has its valid cleared, because the younger pipeline write wins. A same-cycle push with a matching thread/addr is also written with valid=0.
- Starvation counter:
  - Increments when the FIFO is non-empty and pv=1; resets to 0 otherwise.
  - wb_stall_req=1 (registered) while counter >= STARVE_MAX; clears the cycle after the counter resets.
- flush: affects only the current MEM/WB entry; FIFO contents survive a flush.

Test Plan:
1. Pipeline-only: mem_en=1, mem_gpr_we_=0, thread 1, addr 5, data 0xDEADBEEF → next cycle gpr_we_=0, gpr_thread=1, gpr_wr_addr=5, gpr_wr_data=0xDEADBEEF, wb_fwd_data equal; with addr 0 → gpr_we_ stays 1.
2. Late load into idle pipe: ld_rdy one cycle, thread 2, addr 7, data 0x12345678 → gpr_we_=0 with those values exactly 2 cycles after acceptance; FIFO empty afterwards.
3. Full/backpressure:
   - Push 5 loads while pv=1 continuously → ld_full=1 after the 4th push; 5th refused and held.
   - Release the pipeline → entries drain in order, one per cycle; 5th accepted once count<4.
4. Kill: FIFO holds (thread 0, addr 3, 0xAAAA); pipeline writes thread 0, addr 3, 0xBBBB → register written 0xBBBB; later drain of that entry gives gpr_we_=1. An entry with the same addr but thread 1 is still written.
5. Starvation: FIFO non-empty, pv=1 for 8 consecutive cycles → wb_stall_req=1 on the following cycle; assert stall → FIFO head written next cycle, wb_stall_req drops.
6. Reset mid-drain: FIFO holding 3 entries, reset pulsed low → all outputs at reset values immediately; after release no writes issued, ld_full=0.

Source files
------------

// File: rtl/wb_stage_if.sv
// Write-back stage bus bundle: MEM/WB entry, late-load return path and GPR write port.
interface wb_stage_if;
  logic        stall;
  logic        flush;
  logic        mem_en;
  logic [1:0]  mem_thread;
  logic [4:0]  mem_dst_addr;
  logic        mem_gpr_we_;
  logic [31:0] mem_out;
  logic        ld_rdy;
  logic [1:0]  ld_thread;
  logic [4:0]  ld_dst_addr;
  logic [31:0] ld_data;
  logic        ld_full;
  logic        gpr_we_;
  logic [1:0]  gpr_thread;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;
  logic [31:0] wb_fwd_data;
  logic        wb_stall_req;

  modport master (
    output stall, flush, mem_en, mem_thread, mem_dst_addr, mem_gpr_we_, mem_out,
           ld_rdy, ld_thread, ld_dst_addr, ld_data,
    input  ld_full, gpr_we_, gpr_thread, gpr_wr_addr, gpr_wr_data, wb_fwd_data, wb_stall_req
  );

  modport slave (
    input  stall, flush, mem_en, mem_thread, mem_dst_addr, mem_gpr_we_, mem_out,
           ld_rdy, ld_thread, ld_dst_addr, ld_data,
    output ld_full, gpr_we_, gpr_thread, gpr_wr_addr, gpr_wr_data, wb_fwd_data, wb_stall_req
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates MEM/WB results and buffered late loads onto the GPR write port,
// kills stale late loads and requests an upstream stall when the load buffer starves.
module wb_stage #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic      clk,
  input  logic      reset,
  wb_stage_if.slave wb
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        vld;
    logic [1:0]  thread;
    logic [4:0]  dst;
    logic [31:0] data;
  } ld_ent_t;

  ld_ent_t       fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          full_q, stall_req_q;
  logic          we_n_q;
  logic [1:0]    thread_q;
  logic [4:0]    addr_q;
  logic [31:0]   data_q, fwd_q;

  logic    pv_c, empty_c, push_c, pop_c, push_kill_c;
  ld_ent_t head_c;

  // Port arbitration, FIFO occupancy and starvation bookkeeping
  always_comb begin
    pv_c        = wb.mem_en & ~wb.mem_gpr_we_ & ~wb.stall & ~wb.flush & (wb.mem_dst_addr != 5'd0);
    empty_c     = (count_q == '0);
    push_c      = wb.ld_rdy & ~full_q;
    pop_c       = ~pv_c & ~empty_c;
    push_kill_c = pv_c & (wb.ld_thread == wb.mem_thread) & (wb.ld_dst_addr == wb.mem_dst_addr);
    head_c      = fifo_q[rd_ptr_q];
    count_d     = count_q + CW'(push_c) - CW'(pop_c);
    starve_d    = '0;
    if (pv_c && !empty_c) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    end
  end

  // Late-load FIFO; a younger pipeline write invalidates matching resident entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[PW'(i)] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
    end else begin
      if (pv_c) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (fifo_q[PW'(i)].thread == wb.mem_thread && fifo_q[PW'(i)].dst == wb.mem_dst_addr)
            fifo_q[PW'(i)].vld <= 1'b0;
        end
      end
      if (push_c) begin
        fifo_q[wr_ptr_q] <= '{vld: ~push_kill_c, thread: wb.ld_thread,
                              dst: wb.ld_dst_addr, data: wb.ld_data};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      full_q      <= (count_d == CW'(DEPTH));
      starve_q    <= starve_d;
      stall_req_q <= (starve_d >= SW'(STARVE_MAX));
    end
  end

  // GPR write port; killed or r0 heads drain without a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_n_q   <= 1'b1;
      thread_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      fwd_q    <= '0;
    end else if (pv_c) begin
      we_n_q   <= 1'b0;
      thread_q <= wb.mem_thread;
      addr_q   <= wb.mem_dst_addr;
      data_q   <= wb.mem_out;
      fwd_q    <= wb.mem_out;
    end else if (pop_c && head_c.vld && head_c.dst != 5'd0) begin
      we_n_q   <= 1'b0;
      thread_q <= head_c.thread;
      addr_q   <= head_c.dst;
      data_q   <= head_c.data;
      fwd_q    <= head_c.data;
    end else begin
      we_n_q   <= 1'b1;
    end
  end

  assign wb.ld_full      = full_q;
  assign wb.gpr_we_      = we_n_q;
  assign wb.gpr_thread   = thread_q;
  assign wb.gpr_wr_addr  = addr_q;
  assign wb.gpr_wr_data  = data_q;
  assign wb.wb_fwd_data  = fwd_q;
  assign wb.wb_stall_req = stall_req_q;
endmodule
